// File: rtl/regbank_write_arbiter.sv
// Write-port arbiter for the 32x32 register bank: zero sweep after reset, then
// round-robin between ALU (A) and load (B) writeback, plus read-after-write hazard flags.
module regbank_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state;
    logic [ADDR_W:0]     sweep_cnt;   // extra MSB marks "every register written"
    logic                last_b;      // 1: B won the last contested cycle
    logic                run;
    logic                grant;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    always_comb begin
        run      = (state == S_RUN);
        a_ready  = run & a_valid & (~b_valid | last_b);
        b_ready  = run & b_valid & (~a_valid | ~last_b);
        grant    = a_ready | b_ready;
        sel_addr = a_ready ? a_addr : b_addr;
        sel_data = a_ready ? a_data : b_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_INIT;
            sweep_cnt <= '0;
            last_b    <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (sweep_cnt[ADDR_W]) begin
                        wr_en     <= 1'b0;
                        init_done <= 1'b1;
                        state     <= S_RUN;
                    end else begin
                        wr_en     <= 1'b1;
                        wr_addr   <= sweep_cnt[ADDR_W-1:0];
                        wr_data   <= '0;
                        sweep_cnt <= sweep_cnt + (ADDR_W+1)'(1);
                    end
                end
                S_RUN: begin
                    wr_en <= 1'b0;
                    // Round-robin pointer only moves when both requesters compete.
                    if (a_valid & b_valid)
                        last_b <= b_ready;
                    // r0 stays zero: accept the request but suppress the write.
                    if (grant && sel_addr != '0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= sel_addr;
                        wr_data <= sel_data;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign hazard1 = init_done & wr_en & (wr_addr == rd_addr1) & (rd_addr1 != '0);
    assign hazard2 = init_done & wr_en & (wr_addr == rd_addr2) & (rd_addr2 != '0);

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares the single write port of the 32x32 register bank between two writeback requesters: A (ALU result) and B (memory load).
- After reset, sweeps the whole bank to zero, so every register has a defined value before the core issues.
- Flags read-after-write hazards for the bank's two read addresses while a write is in flight.
- Sits between the execute/memory stages and the register bank's write-enable, write-address and write-data inputs.

Parameters:
- ADDR_W, 5, register address width; bank depth = 2**ADDR_W.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  destination register, A.
- a_data  input  DATA_W  write data, A.
- a_ready  output  1  A's request accepted this cycle.
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  destination register, B.
- b_data  input  DATA_W  write data, B.
- b_ready  output  1  B's request accepted this cycle.
- wr_en  output  1  write enable to the bank.
- wr_addr  output  ADDR_W  write address to the bank.
- wr_data  output  DATA_W  write data to the bank.
- rd_addr1  input  ADDR_W  bank read address 1 (monitored only).
- rd_addr2  input  ADDR_W  bank read address 2 (monitored only).
- hazard1  output  1  rd_addr1 matches the write in flight.
- hazard2  output  1  rd_addr2 matches the write in flight.
- init_done  output  1  zero sweep finished; arbiter accepting requests.

Behaviour:
- Clock and reset: one clock, clk; rst_n is synchronous and active-low.
- Reset values (sampled rst_n=0 at the clk edge):
  - wr_en=0, wr_addr=0, wr_data=0, init_done=0.
  - FSM=INIT, sweep counter=0, last_grant=B, so A wins the first tie.
- rst_n asserted mid-sweep or mid-traffic:
  - Aborts the current activity; any unissued write is dropped.
  - The sweep restarts from register 0.
- FSM INIT:
  - Each cycle: wr_en=1, wr_addr=counter, wr_data=0; counter increments.
  - a_ready=b_ready=0.
  - After the cycle writing address 2**ADDR_W-1, go to RUN and set init_done=1 (registered).
  - INIT lasts exactly 2**ADDR_W cycles after reset release.
- FSM RUN, arbitration (combinational ready):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the requester that is not last_grant (round-robin), then update last_grant to the winner.
  - At most one ready high per cycle.
  - Handshake = valid & ready. A requester must hold valid, addr and data stable until it sees ready.
- Write latency: exactly 1 cycle.
  - A handshake in cycle N drives wr_en=1, wr_addr, wr_data (registered) in cycle N+1.
  - No handshake in cycle N gives wr_en=0 in N+1; wr_addr and wr_data hold their previous values.
- Register 0:
  - A handshake with addr=0 is accepted (ready=1) but produces wr_en=0 in N+1.
  - Register 0 is written only by the INIT sweep.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate A,B,A,B.
- Hazards (combinational, on registered outputs):
  - hazard1 = wr_en & (wr_addr==rd_addr1) & (rd_addr1!=0); hazard2 is the same using rd_addr2.
  - Both hazard outputs are 0 during INIT.
- There are no other states. No error outputs.

Test Plan:
- Reset then release: wr_en=1 for 32 consecutive cycles with wr_addr 0..31 and wr_data=0; init_done rises on the next cycle; a_ready=0 throughout.
- In RUN, A only, a_addr=5, a_data=0xDEADBEEF: a_ready=1 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
- A and B both valid for 4 cycles (A: addr 3, data 0x11; B: addr 4, data 0x22): grant order A,B,A,B; wr_addr sequence 3,4,3,4 with 1-cycle lag.
- B valid with b_addr=0, b_data=0xFFFFFFFF: b_ready=1; next cycle wr_en=0.
- Write to 7 in flight with rd_addr1=7, rd_addr2=0: hazard1=1, hazard2=0. Next cycle, with no write: hazard1=0.
- Assert rst_n=0 at sweep count 10, release: sweep restarts at wr_addr=0 and takes a full 32 cycles; init_done stays 0 until complete.
